// File: rtl/regfile_state_mp.sv
// regfile_state_mp: append-only state store for call frames.
// Each entry is {pos[3:0], parent_addr[11:0], done}. Entries are appended at
// wr_ptr, consumed in order through a sequential read port, inspected through
// a random read port, and their done flag can be rewritten in place.
// Both read ports have one cycle of registered latency and return memory
// contents as they were before the same edge's append/update.
module regfile_state_mp #(
    parameter int DATA_WIDTH = 17,
    parameter int ADDR_WIDTH = 12,
    parameter int DEPTH      = 4096,
    parameter int DONE_BIT   = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  we,
    input  logic [DATA_WIDTH-1:0] w_data,
    output logic [ADDR_WIDTH-1:0] w_addr,
    output logic                  full,
    output logic                  overflow,
    input  logic                  upd_en,
    input  logic [ADDR_WIDTH-1:0] upd_addr,
    input  logic                  upd_done,
    input  logic                  seq_re,
    output logic                  seq_r_valid,
    output logic [DATA_WIDTH-1:0] seq_r_data,
    output logic [ADDR_WIDTH-1:0] seq_r_addr,
    output logic                  seq_empty,
    input  logic                  ran_re,
    input  logic [ADDR_WIDTH-1:0] ran_r_addr,
    output logic                  ran_r_valid,
    output logic [DATA_WIDTH-1:0] ran_r_data,
    output logic [ADDR_WIDTH-1:0] ran_r_addr_o,
    output logic                  ran_r_err,
    output logic                  conflict,
    output logic [ADDR_WIDTH:0]   count
);

    // Pointers carry one extra bit so "full" (wr_ptr == DEPTH) is representable.
    localparam int PW = ADDR_WIDTH + 1;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic [PW-1:0]         r_wr_ptr;
    logic [PW-1:0]         r_rd_ptr;
    logic [ADDR_WIDTH-1:0] r_w_addr;
    logic                  r_overflow;

    logic                  r_seq_r_valid;
    logic [DATA_WIDTH-1:0] r_seq_r_data;
    logic [ADDR_WIDTH-1:0] r_seq_r_addr;

    logic                  r_ran_r_valid;
    logic [DATA_WIDTH-1:0] r_ran_r_data;
    logic [ADDR_WIDTH-1:0] r_ran_r_addr_o;
    logic                  r_ran_r_err;
    logic                  r_conflict;

    logic w_full;
    logic w_empty;
    logic w_wr_fire;
    logic w_upd_fire;
    logic w_seq_fire;
    logic w_ran_hit;

    // Status is derived from the pre-edge pointers; clr overrides every request.
    assign w_full     = (r_wr_ptr == PW'(DEPTH));
    assign w_empty    = (r_rd_ptr == r_wr_ptr);
    assign w_wr_fire  = we & ~w_full & ~clr;
    assign w_upd_fire = upd_en & ~clr & ({1'b0, upd_addr} < r_wr_ptr);
    assign w_seq_fire = seq_re & ~w_empty & ~ran_re & ~clr;
    assign w_ran_hit  = ({1'b0, ran_r_addr} < r_wr_ptr);

    // Storage: append write plus in-place done-flag rewrite. An accepted update
    // always targets an address below wr_ptr, so it never collides with the append.
    // NOTE: the array is deliberately left out of reset; only pointers mark validity,
    // and a resettable 4K-entry array would prevent mapping it onto block RAM.
    always_ff @(posedge clk) begin
        if (w_wr_fire) begin
            r_mem[r_wr_ptr[ADDR_WIDTH-1:0]] <= w_data;
        end
        if (w_upd_fire) begin
            r_mem[upd_addr][DONE_BIT] <= upd_done;
        end
    end

    // Pointers, last-write address and sticky overflow.
    // NOTE: every clocked block uses non-blocking assignments so all registers
    // sample pre-edge values; that is what gives read-before-write behaviour.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_w_addr   <= '0;
            r_overflow <= 1'b0;
        end else if (clr) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_w_addr   <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr_fire) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
                r_w_addr <= r_wr_ptr[ADDR_WIDTH-1:0];
            end
            if (we && w_full) begin
                r_overflow <= 1'b1;
            end
            if (w_seq_fire) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    // Sequential read port: valid is a pulse, data/address hold their last value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seq_r_valid <= 1'b0;
            r_seq_r_data  <= '0;
            r_seq_r_addr  <= '0;
        end else if (clr) begin
            r_seq_r_valid <= 1'b0;
            r_seq_r_data  <= '0;
            r_seq_r_addr  <= '0;
        end else begin
            r_seq_r_valid <= w_seq_fire;
            if (w_seq_fire) begin
                r_seq_r_data <= r_mem[r_rd_ptr[ADDR_WIDTH-1:0]];
                r_seq_r_addr <= r_rd_ptr[ADDR_WIDTH-1:0];
            end
        end
    end

    // Random read port: wins over the sequential port; unwritten addresses return
    // zero with an error pulse. Conflict pulses alongside the random valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ran_r_valid  <= 1'b0;
            r_ran_r_data   <= '0;
            r_ran_r_addr_o <= '0;
            r_ran_r_err    <= 1'b0;
            r_conflict     <= 1'b0;
        end else if (clr) begin
            r_ran_r_valid  <= 1'b0;
            r_ran_r_data   <= '0;
            r_ran_r_addr_o <= '0;
            r_ran_r_err    <= 1'b0;
            r_conflict     <= 1'b0;
        end else begin
            r_ran_r_valid <= ran_re;
            r_ran_r_err   <= ran_re & ~w_ran_hit;
            r_conflict    <= ran_re & seq_re;
            if (ran_re) begin
                r_ran_r_addr_o <= ran_r_addr;
                r_ran_r_data   <= w_ran_hit ? r_mem[ran_r_addr] : '0;
            end
        end
    end

    assign w_addr       = r_w_addr;
    assign full         = w_full;
    assign overflow     = r_overflow;
    assign seq_r_valid  = r_seq_r_valid;
    assign seq_r_data   = r_seq_r_data;
    assign seq_r_addr   = r_seq_r_addr;
    assign seq_empty    = w_empty;
    assign ran_r_valid  = r_ran_r_valid;
    assign ran_r_data   = r_ran_r_data;
    assign ran_r_addr_o = r_ran_r_addr_o;
    assign ran_r_err    = r_ran_r_err;
    assign conflict     = r_conflict;
    assign count        = r_wr_ptr;

endmodule

// File: tb/tb_regfile_state_mp.sv
// Testbench for regfile_state_mp: directed scenarios, a frame-store model that
// predicts every output after each edge, and literal expectations per scenario.
module tb_regfile_state_mp;

    localparam int DW    = 17;
    localparam int AW    = 12;
    localparam int DEPTH = 4096;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          clr, we, upd_en, upd_done, seq_re, ran_re;
    logic [DW-1:0] w_data;
    logic [AW-1:0] upd_addr, ran_r_addr;
    logic [AW-1:0] w_addr, seq_r_addr, ran_r_addr_o;
    logic [DW-1:0] seq_r_data, ran_r_data;
    logic          full, overflow, seq_r_valid, seq_empty, ran_r_valid, ran_r_err, conflict;
    logic [AW:0]   count;

    regfile_state_mp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .DONE_BIT(0)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .we(we), .w_data(w_data), .w_addr(w_addr),
        .full(full), .overflow(overflow), .upd_en(upd_en), .upd_addr(upd_addr),
        .upd_done(upd_done), .seq_re(seq_re), .seq_r_valid(seq_r_valid),
        .seq_r_data(seq_r_data), .seq_r_addr(seq_r_addr), .seq_empty(seq_empty),
        .ran_re(ran_re), .ran_r_addr(ran_r_addr), .ran_r_valid(ran_r_valid),
        .ran_r_data(ran_r_data), .ran_r_addr_o(ran_r_addr_o), .ran_r_err(ran_r_err),
        .conflict(conflict), .count(count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model: frame list plus expected port values ----------------
    logic [DW-1:0] m_mem [DEPTH];
    int            m_wr, m_rd;
    bit            m_ovf;
    bit            e_seq_v, e_ran_v, e_err, e_conf;
    logic [DW-1:0] e_seq_data, e_ran_data;
    int            e_seq_addr, e_ran_addr, e_waddr;

    task automatic model_reset();
        m_wr = 0; m_rd = 0; m_ovf = 0;
        e_seq_v = 0; e_ran_v = 0; e_err = 0; e_conf = 0;
        e_seq_data = '0; e_ran_data = '0;
        e_seq_addr = 0; e_ran_addr = 0; e_waddr = 0;
    endtask

    // One clock edge worth of behaviour, evaluated with pre-edge state.
    task automatic model_step();
        if (!rst_n || clr) begin
            model_reset();
            return;
        end
        e_seq_v = 0; e_ran_v = 0; e_err = 0;
        e_conf  = seq_re && ran_re;
        if (ran_re) begin
            e_ran_v    = 1;
            e_ran_addr = int'(ran_r_addr);
            if (int'(ran_r_addr) < m_wr) e_ran_data = m_mem[ran_r_addr];
            else begin e_ran_data = '0; e_err = 1; end
        end else if (seq_re && m_rd < m_wr) begin
            e_seq_v    = 1;
            e_seq_data = m_mem[m_rd];
            e_seq_addr = m_rd;
            m_rd++;
        end
        if (upd_en && int'(upd_addr) < m_wr) m_mem[upd_addr][0] = upd_done;
        if (we) begin
            if (m_wr < DEPTH) begin
                m_mem[m_wr] = w_data;
                e_waddr = m_wr;
                m_wr++;
            end else m_ovf = 1;
        end
    endtask

    // Compare process: every output against the model, mid-cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            check("count",        32'(count),        32'(m_wr));
            check("full",         32'(full),         32'(m_wr == DEPTH));
            check("seq_empty",    32'(seq_empty),    32'(m_rd == m_wr));
            check("overflow",     32'(overflow),     32'(m_ovf));
            check("w_addr",       32'(w_addr),       32'(e_waddr));
            check("seq_r_valid",  32'(seq_r_valid),  32'(e_seq_v));
            check("seq_r_data",   32'(seq_r_data),   32'(e_seq_data));
            check("seq_r_addr",   32'(seq_r_addr),   32'(e_seq_addr));
            check("ran_r_valid",  32'(ran_r_valid),  32'(e_ran_v));
            check("ran_r_data",   32'(ran_r_data),   32'(e_ran_data));
            check("ran_r_addr_o", 32'(ran_r_addr_o), 32'(e_ran_addr));
            check("ran_r_err",    32'(ran_r_err),    32'(e_err));
            check("conflict",     32'(conflict),     32'(e_conf));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic idle();
        clr = 0; we = 0; w_data = '0; upd_en = 0; upd_addr = '0; upd_done = 0;
        seq_re = 0; ran_re = 0; ran_r_addr = '0;
    endtask

    // Inputs are already set; advance one edge and return just after it.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic wr(input logic [DW-1:0] d);
        idle(); we = 1; w_data = d; tick(); idle();
    endtask

    task automatic seq_rd();
        idle(); seq_re = 1; tick(); idle();
    endtask

    task automatic ran_rd(input logic [AW-1:0] a);
        idle(); ran_re = 1; ran_r_addr = a; tick(); idle();
    endtask

    task automatic do_clr();
        idle(); clr = 1; tick(); idle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        model_reset();
        #2 rst_n = 0;
        #1 chk_en = 1;
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1;

        // 1: three appends, then drain in order
        check("t1_reset_count", 32'(count), 32'd0);
        check("t1_reset_empty", 32'(seq_empty), 32'd1);
        wr(17'h0ABCD); wr(17'h15555); wr(17'h0F0F1);
        check("t1_count", 32'(count), 32'd3);
        check("t1_w_addr", 32'(w_addr), 32'd2);
        seq_rd();
        check("t1_rdA_v", 32'(seq_r_valid), 32'd1);
        check("t1_rdA_d", 32'(seq_r_data), 32'h0ABCD);
        check("t1_rdA_a", 32'(seq_r_addr), 32'd0);
        seq_rd();
        check("t1_rdB_d", 32'(seq_r_data), 32'h15555);
        check("t1_rdB_a", 32'(seq_r_addr), 32'd1);
        seq_rd();
        check("t1_rdC_d", 32'(seq_r_data), 32'h0F0F1);
        check("t1_rdC_a", 32'(seq_r_addr), 32'd2);
        seq_rd();
        check("t1_rd4_v", 32'(seq_r_valid), 32'd0);
        check("t1_empty", 32'(seq_empty), 32'd1);

        // 2: fill to DEPTH, one extra write overflows, clr recovers
        for (int i = 3; i < DEPTH; i++) wr(DW'(i * 37));
        check("t2_full_pre", 32'(full), 32'd1);
        check("t2_ovf_pre", 32'(overflow), 32'd0);
        wr(17'h1AAAA);
        check("t2_full", 32'(full), 32'd1);
        check("t2_overflow", 32'(overflow), 32'd1);
        check("t2_count", 32'(count), 32'd4096);
        do_clr();
        check("t2_clr_count", 32'(count), 32'd0);
        check("t2_clr_ovf", 32'(overflow), 32'd0);
        check("t2_clr_full", 32'(full), 32'd0);

        // 3: done-flag update racing a random read of the same slot
        for (int i = 0; i < 5; i++) wr(DW'(17'h00100 + i));
        wr(17'h1FFFE);
        idle(); upd_en = 1; upd_addr = 12'd5; upd_done = 1; ran_re = 1; ran_r_addr = 12'd5;
        tick(); idle();
        check("t3_rbw_data", 32'(ran_r_data), 32'h1FFFE);
        ran_rd(12'd5);
        check("t3_upd_data", 32'(ran_r_data), 32'h1FFFF);
        check("t3_upd_err", 32'(ran_r_err), 32'd0);

        // 4: simultaneous seq and random read, random wins
        do_clr();
        wr(17'h00A01); wr(17'h00B02); wr(17'h00C03);
        idle(); seq_re = 1; ran_re = 1; ran_r_addr = 12'd1; tick(); idle();
        check("t4_ran_data", 32'(ran_r_data), 32'h00B02);
        check("t4_conflict", 32'(conflict), 32'd1);
        check("t4_seq_v", 32'(seq_r_valid), 32'd0);
        seq_rd();
        check("t4_seq_addr", 32'(seq_r_addr), 32'd0);
        check("t4_seq_data", 32'(seq_r_data), 32'h00A01);
        check("t4_conflict_drop", 32'(conflict), 32'd0);

        // 5: reads and updates at address == count are rejected
        ran_rd(12'd3);
        check("t5_err", 32'(ran_r_err), 32'd1);
        check("t5_data", 32'(ran_r_data), 32'd0);
        idle(); upd_en = 1; upd_addr = 12'd3; upd_done = 1; tick(); idle();
        wr(17'h01230);
        ran_rd(12'd3);
        check("t5_no_upd", 32'(ran_r_data), 32'h01230);

        // 6: async reset with reads pending
        idle(); seq_re = 1; ran_re = 1; ran_r_addr = 12'd0;
        #2 rst_n = 0;
        model_reset();
        tick(); idle();
        check("t6_seq_v", 32'(seq_r_valid), 32'd0);
        check("t6_ran_v", 32'(ran_r_valid), 32'd0);
        check("t6_count", 32'(count), 32'd0);
        check("t6_empty", 32'(seq_empty), 32'd1);
        rst_n = 1;
        wr(17'h00777);
        seq_rd();
        check("t6_after_d", 32'(seq_r_data), 32'h00777);

        @(negedge clk);
        #1 chk_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
